ifu_prefetch: RTL and testbench
===============================

IFU_PREFETCH -- requirements
Module: ifu_prefetch

Interface
REQ-001 Parameter XLEN, default 32: address/PC width in bits.
REQ-002 Parameter DEPTH, default 2: prefetch buffer entries; power of two, >= 2.
REQ-003 Parameter RESET_PC, default 32'h8000_0000: first fetch address after reset.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port rst, input, 1: reset, synchronous, active-low.
REQ-006 Port redirect_valid, input, 1: flush and restart fetch at redirect_pc.
REQ-007 Port redirect_pc, input, XLEN: new fetch address; bits [1:0] are ignored and treated as 0.
REQ-008 Port mem_req_valid, output, 1: fetch request valid.
REQ-009 Port mem_req_ready, input, 1: memory accepts the request.
REQ-010 Port mem_req_addr, output, XLEN: fetch address.
REQ-011 Port mem_rsp_valid, input, 1: response valid, single-cycle pulse; the memory cannot stall it.
REQ-012 Port mem_rsp_data, input, 32: instruction word.
REQ-013 Port mem_rsp_err, input, 1: access fault for this response.
REQ-014 Port out_valid, output, 1: instruction available to the decoder.
REQ-015 Port out_ready, input, 1: decoder accepts the instruction.
REQ-016 Port out_pc, output, XLEN; out_inst, output, 32; out_err, output, 1: head-entry fields.

Function
REQ-017 The FSM SHALL have three states: REQ, WAIT and DROP.
- At most one memory request is outstanding at any time.
REQ-018 In REQ, mem_req_valid SHALL be 1 iff (fifo_count + 0) < DEPTH, and mem_req_addr SHALL equal fetch_pc.
- On mem_req_valid & mem_req_ready: latch req_pc = fetch_pc, set fetch_pc += 4 (XLEN wrap-around), go to WAIT.
REQ-019 Once asserted, mem_req_valid and mem_req_addr SHALL stay stable until accepted.
- Only exception: redirect_valid, after which the address changes on the next cycle.
REQ-020 In WAIT, on mem_rsp_valid the block SHALL push {req_pc, mem_rsp_data, mem_rsp_err} into the buffer and go to REQ.
- Buffer space is guaranteed by REQ-018, so the push cannot overflow.
REQ-021 out_valid SHALL equal buffer-not-empty, and out_pc/out_inst/out_err SHALL come directly from the head entry.
- Pop on out_valid & out_ready.
- Push and pop in the same cycle SHALL both take effect.
REQ-022 Latency: an instruction SHALL reach out_valid the cycle after its mem_rsp_valid.
- Sustained throughput SHALL be one instruction per 2 cycles with 1-cycle memory.
REQ-023 On redirect_valid the block SHALL, in the same clock edge:
- empty the buffer;
- set fetch_pc = {redirect_pc[XLEN-1:2], 2'b00};
- go to DROP if a request is outstanding after this edge (in WAIT without mem_rsp_valid, or a REQ handshake in this cycle), else go to REQ.
REQ-024 In DROP, the next mem_rsp_valid SHALL be discarded (no push) and the FSM SHALL go to REQ.
- mem_req_valid SHALL be 0 while in DROP.
REQ-025 A redirect in WAIT coinciding with mem_rsp_valid SHALL discard that response and go to REQ.
REQ-026 A redirect coinciding with an out_valid & out_ready pop SHALL still empty the buffer, and the popped entry SHALL count as consumed.
REQ-027 mem_rsp_err SHALL NOT stop fetching; it is only carried to out_err for that entry.
REQ-028 mem_rsp_valid arriving in REQ state SHALL be ignored.

Reset
REQ-029 While rst=0 at a clock edge, the block SHALL set: state=REQ, fetch_pc=RESET_PC, buffer empty, req_pc=0.
REQ-030 mem_req_valid and out_valid SHALL be 0 in any cycle where rst=0, including combinationally.
REQ-031 Reset during WAIT SHALL abandon the outstanding request without entering DROP.
- The memory model is reset together with this block.

Structure
REQ-032 A shared package ifu_pkg SHALL hold the FSM state enum (REQ/WAIT/DROP), the instruction width constant 32 and the default RESET_PC.
REQ-033 The buffer SHALL be a separate sub-module ifu_fifo with these properties:
- synchronous, parameters DEPTH and WIDTH=XLEN+33;
- flush input, count output;
- first-word-fall-through head.

Verification
REQ-034 Reset release with 1-cycle memory and out_ready=1 -> out_pc sequence 0x80000000, 0x80000004, 0x80000008, one output every 2 cycles.
REQ-035 out_ready=0 with DEPTH=2 -> exactly 2 requests issued, then mem_req_valid=0; raising out_ready -> pops in order and fetch resumes at 0x80000008.
REQ-036 Redirect to 0x80001003 while in WAIT -> the stale response is dropped, and the next request address and out_pc are both 0x80001000.
REQ-037 mem_req_ready held 0 for 5 cycles -> mem_req_addr stays 0x80000000 for all 5 cycles; no output.
REQ-038 mem_rsp_err=1 on the second response -> out_err=1 only for out_pc 0x80000004; fetch continues to 0x80000008.
REQ-039 fetch_pc at 0xFFFFFFFC -> the next request wraps to 0x00000000.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction-fetch prefetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_e;

  localparam int unsigned INST_W           = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with first-word-fall-through head, flush and occupancy count.
module ifu_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 65
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, wr_q;
  logic [AW:0]      cnt_q;
  logic             pop_ok, push_ok;

  assign pop_ok  = pop && (cnt_q != '0);
  assign push_ok = push && ((cnt_q != FULL_C) || pop_ok);

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= push_data;
  end

  assign head_data = mem_q[rd_q];
  assign empty     = (cnt_q == '0);
  assign count     = cnt_q;

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetcher: one outstanding fetch at a time into a small FWFT buffer,
// with redirect flush and discard of a stale in-flight response.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int unsigned      XLEN     = 32,
  parameter int unsigned      DEPTH    = 2,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [INST_W-1:0] mem_rsp_data,
  input  logic              mem_rsp_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic              out_err
);

  localparam int unsigned WIDTH = XLEN + 33;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_e           state_q;
  logic [XLEN-1:0]  fetch_pc_q;
  logic [XLEN-1:0]  req_pc_q;

  logic [CW-1:0]    fifo_count;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_head;
  logic             req_fire, rsp_push, out_pop;
  logic [XLEN-1:0]  redirect_aligned;

  assign redirect_aligned = redirect_pc & ~(XLEN'(3));

  // Gated by rst so both handshakes are dead while reset is asserted.
  assign mem_req_valid = rst && (state_q == REQ) && (fifo_count < DEPTH_C);
  assign mem_req_addr  = fetch_pc_q;
  assign out_valid     = rst && !fifo_empty;

  assign req_fire = mem_req_valid && mem_req_ready;
  assign rsp_push = (state_q == WAIT) && mem_rsp_valid && !redirect_valid;
  assign out_pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else if (redirect_valid) begin
      // A request still in flight after this edge must have its response swallowed.
      fetch_pc_q <= redirect_aligned;
      unique case (state_q)
        REQ:     state_q <= req_fire      ? DROP : REQ;
        WAIT:    state_q <= mem_rsp_valid ? REQ  : DROP;
        DROP:    state_q <= mem_rsp_valid ? REQ  : DROP;
        default: state_q <= REQ;
      endcase
    end else begin
      unique case (state_q)
        REQ: if (req_fire) begin
          req_pc_q   <= fetch_pc_q;
          fetch_pc_q <= fetch_pc_q + XLEN'(4);
          state_q    <= WAIT;
        end
        WAIT:    if (mem_rsp_valid) state_q <= REQ;
        DROP:    if (mem_rsp_valid) state_q <= REQ;
        default: state_q <= REQ;
      endcase
    end
  end

  ifu_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (rsp_push),
    .push_data ({req_pc_q, mem_rsp_data, mem_rsp_err}),
    .pop       (out_pop),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign {out_pc, out_inst, out_err} = fifo_head;

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed scoreboard bench for ifu_prefetch with a variable-latency memory model.
module tb_ifu_prefetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        mem_rsp_err = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_err;

  always #5 clk = ~clk;

  ifu_prefetch #(
    .XLEN     (32),
    .DEPTH    (2),
    .RESET_PC (32'h8000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_err    (mem_rsp_err),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_err        (out_err)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } out_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hs_count = 0;
  out_t        exp_q[$];
  logic [31:0] req_q[$];
  int          pop_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Memory: accepts one request, answers mem_lat cycles later.
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_cnt = 0;
  int          mem_lat = 1;
  logic [31:0] err_addr = 32'hFFFF_FFFF;

  always @(negedge clk) begin
    if (!rst) pend = 1'b0;
    else if (mem_req_valid && mem_req_ready) begin
      pend      = 1'b1;
      pend_addr = mem_req_addr;
      pend_cnt  = mem_lat;
    end
  end

  always @(posedge clk) begin
    #1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    mem_rsp_err   = 1'b0;
    if (pend) begin
      if (pend_cnt == 1) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = word_of(pend_addr);
        mem_rsp_err   = (pend_addr == err_addr);
        pend          = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
  end

  // Monitor: compares request addresses and popped outputs against the queues.
  logic [31:0] m_req;
  out_t        m_out;
  always @(negedge clk) begin
    if (rst) begin
      if (mem_req_valid && mem_req_ready) begin
        hs_count++;
        if (req_q.size() > 0) begin
          m_req = req_q.pop_front();
          check("req_addr", mem_req_addr, m_req);
        end
      end
      if (out_valid && out_ready && exp_q.size() > 0) begin
        m_out = exp_q.pop_front();
        check("out_pc",   out_pc,   m_out.pc);
        check("out_inst", out_inst, m_out.inst);
        check("out_err",  32'(out_err), 32'(m_out.err));
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_out(input logic [31:0] pc, input logic err);
    out_t e;
    e.pc   = pc;
    e.inst = word_of(pc);
    e.err  = err;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    mem_req_ready  = 1'b1;
    out_ready      = 1'b1;
    mem_lat        = 1;
    err_addr       = 32'hFFFF_FFFF;
    @(negedge clk);
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    tick(2);
    exp_q.delete();
    req_q.delete();
    pop_cyc.delete();
    hs_count = 0;
    rst = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int bound);
    int k = 0;
    while ((exp_q.size() > 0 || req_q.size() > 0) && k < bound) begin
      tick(1);
      k++;
    end
    check({name, "_out_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_req_left"}, 32'(req_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Straight-line fetch after reset, one output every 2 cycles.
    do_reset();
    req_q = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008};
    exp_out(32'h8000_0000, 1'b0);
    exp_out(32'h8000_0004, 1'b0);
    exp_out(32'h8000_0008, 1'b0);
    wait_drain("t1", 40);
    check("t1_gap01", (pop_cyc.size() >= 3) ? 32'(pop_cyc[1] - pop_cyc[0]) : 32'd0, 32'd2);
    check("t1_gap12", (pop_cyc.size() >= 3) ? 32'(pop_cyc[2] - pop_cyc[1]) : 32'd0, 32'd2);

    // Back-pressure: buffer fills with two entries, then fetch stalls.
    do_reset();
    out_ready = 1'b0;
    tick(12);
    check("t2_hs_count", 32'(hs_count), 32'd2);
    check("t2_req_valid", 32'(mem_req_valid), 32'd0);
    check("t2_out_valid", 32'(out_valid), 32'd1);
    req_q = '{32'h8000_0008};
    exp_out(32'h8000_0000, 1'b0);
    exp_out(32'h8000_0004, 1'b0);
    exp_out(32'h8000_0008, 1'b0);
    out_ready = 1'b1;
    wait_drain("t2", 40);

    // Redirect while waiting on a slow response: stale response dropped.
    do_reset();
    mem_lat = 3;
    req_q = '{32'h8000_0000, 32'h8000_1000};
    exp_out(32'h8000_1000, 1'b0);
    exp_out(32'h8000_1004, 1'b0);
    tick(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_1003;
    tick(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t3_drop_req_valid_a", 32'(mem_req_valid), 32'd0);
    @(negedge clk);
    check("t3_drop_req_valid_b", 32'(mem_req_valid), 32'd0);
    wait_drain("t3", 60);

    // Redirect coinciding with the response in WAIT.
    do_reset();
    req_q = '{32'h8000_0000, 32'h8000_2008, 32'h8000_200C};
    exp_out(32'h8000_2008, 1'b0);
    exp_out(32'h8000_200C, 1'b0);
    tick(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_2008;
    tick(1);
    redirect_valid = 1'b0;
    wait_drain("t4", 40);

    // Redirect coinciding with a pop: popped head consumed, rest flushed.
    do_reset();
    out_ready = 1'b0;
    req_q = '{32'h8000_0000, 32'h8000_0004, 32'h9000_0000};
    exp_out(32'h8000_0000, 1'b0);
    exp_out(32'h9000_0000, 1'b0);
    tick(10);
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h9000_0000;
    tick(1);
    redirect_valid = 1'b0;
    wait_drain("t5", 40);

    // Memory not ready: request held stable, nothing delivered.
    do_reset();
    mem_req_ready = 1'b0;
    req_q = '{32'h8000_0000};
    exp_out(32'h8000_0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t6_req_addr",  mem_req_addr, 32'h8000_0000);
      check("t6_req_valid", 32'(mem_req_valid), 32'd1);
      check("t6_out_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    mem_req_ready = 1'b1;
    wait_drain("t6", 40);

    // Access fault on the second fetch only; fetching continues.
    do_reset();
    err_addr = 32'h8000_0004;
    req_q = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008};
    exp_out(32'h8000_0000, 1'b0);
    exp_out(32'h8000_0004, 1'b1);
    exp_out(32'h8000_0008, 1'b0);
    wait_drain("t7", 40);

    // Address wrap-around at the top of the space; low redirect bits ignored.
    do_reset();
    mem_req_ready  = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    req_q = '{32'hFFFF_FFFC, 32'h0000_0000};
    exp_out(32'hFFFF_FFFC, 1'b0);
    exp_out(32'h0000_0000, 1'b0);
    exp_out(32'h0000_0004, 1'b0);
    tick(1);
    redirect_valid = 1'b0;
    mem_req_ready  = 1'b1;
    wait_drain("t8", 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
